// File: rtl/card_dealer.sv
// Deck reader: fetches one card per request from the shuffled deck RAM in address order,
// tracks the top-of-deck pointer, and flags exhaustion and illegal card codes.
module card_dealer #(
  parameter int DECK_SIZE = 52,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 4
) (
  input  logic              clk,
  input  logic              i_Reset_n,
  input  logic              i_Shuffled,
  input  logic              i_NewDeck,
  input  logic              i_DealReq,
  input  logic [DATA_W-1:0] i_MemData,
  output logic [ADDR_W-1:0] o_Address,
  output logic              o_MemClk,
  output logic [DATA_W-1:0] o_Card,
  output logic              o_CardValid,
  output logic              o_CardErr,
  output logic              o_Ready,
  output logic              o_DeckEmpty,
  output logic [ADDR_W-1:0] o_CardsLeft
);

  localparam int MAX_CODE = 13;

  typedef enum logic [2:0] {
    S_WAIT, S_READY, S_SET, S_READ, S_CAP, S_PRES, S_EMPTY
  } state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt, addr_q, left_q;
  logic [DATA_W-1:0] card_q;
  logic              err_q;

  always_ff @(posedge clk or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= S_WAIT;
    else            state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (i_NewDeck) nxt = S_WAIT;
    else begin
      case (state)
        S_WAIT:  if (i_Shuffled) nxt = S_READY;
        S_READY: if (i_DealReq)  nxt = S_SET;
        S_SET:   nxt = S_READ;
        S_READ:  nxt = S_CAP;
        S_CAP:   nxt = S_PRES;
        S_PRES:  nxt = (ptr == ADDR_W'(DECK_SIZE - 1)) ? S_EMPTY : S_READY;
        S_EMPTY: nxt = S_EMPTY;
        default: nxt = S_WAIT;
      endcase
    end
  end

  // New deck rewinds even when it collides with the post-present increment
  always_comb begin
    ptr_nxt = ptr;
    if (i_NewDeck)            ptr_nxt = '0;
    else if (state == S_PRES) ptr_nxt = ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      ptr    <= '0;
      addr_q <= '0;
      left_q <= ADDR_W'(DECK_SIZE);
      card_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr    <= ptr_nxt;
      left_q <= ADDR_W'(DECK_SIZE) - ptr_nxt;
      if (state == S_READY && i_DealReq && !i_NewDeck) addr_q <= ptr;
      if (state == S_CAP && !i_NewDeck) begin
        card_q <= i_MemData;
        err_q  <= (i_MemData == '0) || (i_MemData > DATA_W'(MAX_CODE));
      end
    end
  end

  always_comb begin
    o_Address   = addr_q;
    o_MemClk    = (state == S_READ);
    o_Card      = card_q;
    o_CardValid = (state == S_PRES);
    o_CardErr   = err_q && (state == S_PRES);
    o_Ready     = (state == S_READY);
    o_DeckEmpty = (state == S_EMPTY);
    o_CardsLeft = left_q;
  end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: directed deals against a behavioural deck RAM.
module tb_card_dealer;
  localparam int DECK = 52;

  logic       clk = 1'b0;
  logic       i_Reset_n, i_Shuffled, i_NewDeck, i_DealReq;
  logic [3:0] i_MemData;
  logic [5:0] o_Address, o_CardsLeft;
  logic       o_MemClk, o_CardValid, o_CardErr, o_Ready, o_DeckEmpty;
  logic [3:0] o_Card;

  card_dealer #(.DECK_SIZE(DECK), .ADDR_W(6), .DATA_W(4)) dut (
    .clk(clk), .i_Reset_n(i_Reset_n), .i_Shuffled(i_Shuffled), .i_NewDeck(i_NewDeck),
    .i_DealReq(i_DealReq), .i_MemData(i_MemData), .o_Address(o_Address),
    .o_MemClk(o_MemClk), .o_Card(o_Card), .o_CardValid(o_CardValid),
    .o_CardErr(o_CardErr), .o_Ready(o_Ready), .o_DeckEmpty(o_DeckEmpty),
    .o_CardsLeft(o_CardsLeft)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [DECK];
  logic [3:0] mem_q = '0;
  int         mc_cnt = 0;
  int         cyc = 0;
  always @(posedge o_MemClk) begin
    mem_q  = mem[o_Address];
    mc_cnt = mc_cnt + 1;
  end
  assign i_MemData = mem_q;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int card; int err; int left; } exp_t;
  exp_t q[$];

  task automatic push(input int card, input int err, input int left);
    exp_t e;
    e.card = card; e.err = err; e.left = left;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation at every strobe, checks the count one cycle later
  bit pend_left = 0;
  int pend_val  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (i_Reset_n) begin
      if (pend_left) begin
        chk("cards_left_after_strobe", o_CardsLeft, pend_val);
        pend_left = 0;
      end
      if (o_CardValid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got card %0d expected no strobe (cycle %0d)", o_Card, cyc);
        end else begin
          e = q.pop_front();
          chk("card", o_Card, e.card);
          chk("card_err", o_CardErr, e.err);
          pend_left = 1;
          pend_val  = e.left;
        end
      end
    end else pend_left = 0;
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!o_Ready && k < 20) begin step(); k++; end
    chk(name, o_Ready, 1);
  endtask

  task automatic wait_strobe(input string name);
    int k = 0;
    step();
    while (!o_CardValid && k < 20) begin step(); k++; end
    chk(name, o_CardValid, 1);
  endtask

  task automatic fill_mem();
    for (int a = 0; a < DECK; a++) mem[a] = 4'((a % 13) + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, mc0, n;
    fill_mem();
    i_Reset_n = 0; i_Shuffled = 0; i_NewDeck = 0; i_DealReq = 0;
    step(2);
    chk("rst_cards_left", o_CardsLeft, 52);
    chk("rst_ready", o_Ready, 0);
    chk("rst_card", o_Card, 0);
    chk("rst_addr", o_Address, 0);
    chk("rst_valid_empty_memclk", {o_CardValid, o_CardErr, o_DeckEmpty, o_MemClk}, 0);
    i_Reset_n = 1;
    step();

    // Single one-cycle request
    i_Shuffled = 1;
    wait_ready("t1_ready");
    push(1, 0, 51);
    i_DealReq = 1; step(); i_DealReq = 0;
    chk("t1_set_memclk", o_MemClk, 0);
    chk("t1_set_addr", o_Address, 0);
    step();
    chk("t1_read_memclk", o_MemClk, 1);
    chk("t1_read_addr", o_Address, 0);
    step();
    chk("t1_cap_memclk", o_MemClk, 0);
    chk("t1_cap_valid", o_CardValid, 0);
    step();
    chk("t1_valid_at_n4", o_CardValid, 1);
    step();
    chk("t1_ready_again", o_Ready, 1);

    // Rewind, then deal the whole deck with the request held
    i_NewDeck = 1; step(); i_NewDeck = 0;
    wait_ready("t2_ready");
    for (int i = 0; i < DECK; i++) push((i % 13) + 1, 0, DECK - 1 - i);
    i_DealReq = 1;
    last = 0;
    for (int i = 0; i < DECK; i++) begin
      wait_strobe("t2_strobe");
      if (i > 0) chk("t2_strobe_gap", cyc - last, 5);
      last = cyc;
    end
    step();
    chk("t2_deck_empty", o_DeckEmpty, 1);
    chk("t2_cards_left_zero", o_CardsLeft, 0);
    mc0 = mc_cnt;
    step(10);
    chk("t2_no_memclk_in_empty", mc_cnt, mc0);
    chk("t2_not_ready_in_empty", o_Ready, 0);

    // New deck and deal request together in EMPTY
    i_Shuffled = 0;
    i_NewDeck = 1; step(); i_NewDeck = 0;
    chk("t6_empty_cleared", o_DeckEmpty, 0);
    chk("t6_cards_left", o_CardsLeft, 52);
    mc0 = mc_cnt;
    step(5);
    chk("t6_no_memclk", mc_cnt, mc0);
    chk("t6_waiting", o_Ready, 0);
    i_DealReq = 0;

    // Illegal codes at addresses 5 and 6
    mem[5] = 4'd0; mem[6] = 4'd14;
    i_Shuffled = 1;
    wait_ready("t3_ready");
    for (int i = 0; i < 7; i++) push(int'(mem[i]), (i >= 5) ? 1 : 0, DECK - 1 - i);
    i_DealReq = 1;
    for (int i = 0; i < 7; i++) wait_strobe("t3_strobe");
    i_DealReq = 0;
    step(2);
    chk("t3_ready", o_Ready, 1);
    chk("t3_cards_left", o_CardsLeft, 45);
    fill_mem();

    // New deck during READ_MEM of the third deal
    i_Shuffled = 0;
    i_NewDeck = 1; step(); i_NewDeck = 0;
    i_Shuffled = 1;
    wait_ready("t4_ready");
    push(1, 0, 51); push(2, 0, 50);
    i_DealReq = 1;
    n = 0;
    for (int k = 0; k < 60 && n < 3; k++) begin
      step();
      if (o_MemClk) n++;
    end
    chk("t4_third_read", n, 3);
    i_NewDeck = 1; i_Shuffled = 0; i_DealReq = 0;
    step(); i_NewDeck = 0;
    chk("t4_cards_left", o_CardsLeft, 52);
    step(8);
    chk("t4_waits_for_shuffle", o_Ready, 0);
    i_Shuffled = 1;
    wait_ready("t4_ready2");
    push(1, 0, 51);
    i_DealReq = 1; step(); i_DealReq = 0;
    chk("t4_addr_zero", o_Address, 0);
    wait_strobe("t4_strobe");
    step();

    // Async reset in the middle of CAPTURE
    wait_ready("t5_ready");
    i_DealReq = 1; step(); i_DealReq = 0;
    step(2);
    chk("t5_cap_addr", o_Address, 1);
    #2 i_Reset_n = 0;
    #1;
    chk("t5_card", o_Card, 0);
    chk("t5_addr", o_Address, 0);
    chk("t5_cards_left", o_CardsLeft, 52);
    chk("t5_flags", {o_CardValid, o_CardErr, o_Ready, o_DeckEmpty, o_MemClk}, 0);
    @(posedge clk); #1 i_Reset_n = 1;
    step(8);

    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Reader side of the deck memory. The shuffler writes the deck; this block reads it back one card per request, in address order 0..DECK_SIZE-1.
- Sits between the shuffled deck RAM and the game controller FSM, which requests cards for player and dealer hands.
- Tracks the top-of-deck pointer, reports cards remaining, and flags deck exhaustion and illegal card codes.

Parameters:
DECK_SIZE, 52, number of cards in the deck; legal addresses are 0..DECK_SIZE-1
ADDR_W, 6, deck memory address width
DATA_W, 4, card code width; legal codes 1..13

Ports:
clk  input  1  system clock, rising edge
i_Reset_n  input  1  asynchronous active-low reset
i_Shuffled  input  1  deck in memory is valid (from shuffler)
i_NewDeck  input  1  synchronous restart: rewind pointer and wait for a new shuffle
i_DealReq  input  1  level request for one card
i_MemData  input  DATA_W  memory read data
o_Address  output  ADDR_W  memory address
o_MemClk  output  1  memory clock pulse
o_Card  output  DATA_W  last card read, held until next capture
o_CardValid  output  1  one-cycle strobe: o_Card is new
o_CardErr  output  1  high with o_CardValid when the captured code is 0 or >13
o_Ready  output  1  idle and able to accept i_DealReq
o_DeckEmpty  output  1  all DECK_SIZE cards dealt
o_CardsLeft  output  ADDR_W  DECK_SIZE minus pointer

Behaviour:
Reset (i_Reset_n=0, async), all outputs:
- State=WAIT_DECK, pointer=0, o_Card=0, o_Address=0.
- o_MemClk=0, o_CardValid=0, o_CardErr=0, o_Ready=0, o_DeckEmpty=0.
- o_CardsLeft=DECK_SIZE.
- A reset mid-deal aborts immediately; no strobe is emitted.

FSM (registered state; Moore outputs, combinational from state):
- WAIT_DECK: o_Ready=0. Go to READY when i_Shuffled=1.
- READY: o_Ready=1.
  - If i_DealReq=1: go to SET_ADDR.
- SET_ADDR: o_Address=pointer, o_MemClk=0. Go to READ_MEM.
- READ_MEM: o_Address=pointer, o_MemClk=1 (memory latches on this rising edge). Go to CAPTURE.
- CAPTURE: o_Address=pointer, o_MemClk=0.
  - i_MemData is registered into o_Card at the end of this cycle.
  - o_CardErr is computed from that value and registered on the same edge.
  - Go to PRESENT.
- PRESENT: o_CardValid=1 for exactly one cycle; pointer increments on exit.
  - Go to EMPTY if pointer==DECK_SIZE-1, otherwise to READY.
- EMPTY: o_DeckEmpty=1, o_Ready=0.
  - i_DealReq is ignored; no memory access.
  - Only i_NewDeck leaves this state.
- o_Address holds its last value in all states not listed above; o_MemClk=0 outside READ_MEM.

Timing and handshake:
- If i_DealReq is sampled high in READY at cycle N, o_CardValid is high in cycle N+4.
- i_DealReq is level-sensitive. If it is still high when the FSM returns to READY, another deal starts, giving one card every 5 cycles.
- The requester drops i_DealReq on seeing o_CardValid.
- o_CardErr is valid only while o_CardValid=1. The card is still counted as dealt.

Pointer and count:
- Pointer is ADDR_W bits and never exceeds DECK_SIZE. It never wraps; EMPTY blocks any further read.
- o_CardsLeft = DECK_SIZE - pointer, registered; it updates the cycle after PRESENT.

i_NewDeck (synchronous, highest priority):
- From any state: pointer=0, o_CardValid=0, o_DeckEmpty=0, next state WAIT_DECK.
- It wins over a simultaneous i_DealReq or PRESENT increment.
- A deal in flight is discarded.
- o_Card keeps its old value.

i_Shuffled:
- Sampled only in WAIT_DECK.
- Deasserting it during dealing has no effect.

Test Plan:
- Memory preloaded with code (addr mod 13)+1; reset; i_Shuffled=1; pulse i_DealReq one cycle in READY -> o_MemClk high exactly 1 cycle with o_Address=0, o_CardValid 4 cycles after request, o_Card=1, o_CardsLeft=51.
- i_DealReq held high for 52 deals -> cards 1,2,...,13,1,... in order, strobe every 5 cycles, o_DeckEmpty=1 after 52nd, o_CardsLeft=0, no further o_MemClk pulses while req stays high.
- Address 5 holds code 0 and address 6 holds 14 -> o_CardErr=1 on the 6th and 7th strobes only; the pointer still advances.
- i_NewDeck asserted in READ_MEM of the 3rd deal -> no strobe for that deal, pointer=0, FSM waits in WAIT_DECK until i_Shuffled; next deal returns address 0.
- i_Reset_n pulled low mid-CAPTURE (asynchronous, between edges) -> all outputs go to reset values immediately; o_CardsLeft=52.
- i_NewDeck and i_DealReq high together in EMPTY -> WAIT_DECK; no memory access; o_DeckEmpty cleared next cycle.
